// File: rtl/id_issue_pkg.sv
// Shared constants for the ID/EX issue register: forwarding source indices,
// default widths and source-used bit positions.
package id_issue_pkg;

  localparam int unsigned FWD_SRC_EX  = 0;
  localparam int unsigned FWD_SRC_MEM = 1;
  localparam int unsigned FWD_SRC_WB  = 2;

  localparam int unsigned SRC_USED_A = 0;
  localparam int unsigned SRC_USED_B = 1;

  localparam int unsigned DEF_DATA_W    = 32;
  localparam int unsigned DEF_REG_AW    = 5;
  localparam int unsigned DEF_NUM_FWD   = 3;
  localparam int unsigned DEF_PAYLOAD_W = 48;
  localparam int unsigned DEF_CNT_W     = 16;

  // Packed ID/EX entry: {ra_data, rb_data, ra_addr, rb_addr, dst_addr, gpr_we_, is_load, payload}
  function automatic int unsigned entry_w(int unsigned data_w, int unsigned reg_aw,
                                          int unsigned payload_w);
    return 2 * data_w + 3 * reg_aw + 2 + payload_w;
  endfunction

endpackage

// File: rtl/id_fwd_sel.sv
// Priority forwarding match/mux for one source operand; lowest source index
// (youngest) wins, and a pending winner raises hazard instead of supplying data.
module id_fwd_sel
  import id_issue_pkg::*;
#(
  parameter int unsigned DATA_W   = DEF_DATA_W,
  parameter int unsigned REG_AW   = DEF_REG_AW,
  parameter int unsigned NUM_FWD  = DEF_NUM_FWD,
  parameter int unsigned ZERO_REG = 1
) (
  input  logic                      used,
  input  logic [REG_AW-1:0]         addr,
  input  logic [DATA_W-1:0]         rf_data,
  input  logic [NUM_FWD-1:0]        fwd_we_,
  input  logic [NUM_FWD-1:0]        fwd_rdy,
  input  logic [NUM_FWD*REG_AW-1:0] fwd_addr,
  input  logic [NUM_FWD*DATA_W-1:0] fwd_data,
  output logic [DATA_W-1:0]         data,
  output logic                      hazard
);

  logic found;

  always_comb begin
    data   = rf_data;
    hazard = 1'b0;
    found  = 1'b0;
    if (ZERO_REG != 0 && addr == '0) begin
      data = '0;
    end else if (used) begin
      for (int i = 0; i < NUM_FWD; i++) begin
        if (!found && !fwd_we_[i] && fwd_addr[i*REG_AW +: REG_AW] == addr) begin
          found = 1'b1;
          if (fwd_rdy[i]) data = fwd_data[i*DATA_W +: DATA_W];
          else            hazard = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/id_issue_reg.sv
// ID/EX issue register: resolves operands from forwarding sources, interlocks on
// pending loads and holds results in a valid/ready register with a one-entry skid.
module id_issue_reg
  import id_issue_pkg::*;
#(
  parameter int unsigned DATA_W    = DEF_DATA_W,
  parameter int unsigned REG_AW    = DEF_REG_AW,
  parameter int unsigned NUM_FWD   = DEF_NUM_FWD,
  parameter int unsigned PAYLOAD_W = DEF_PAYLOAD_W,
  parameter int unsigned CNT_W     = DEF_CNT_W,
  parameter int unsigned ZERO_REG  = 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      flush,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [REG_AW-1:0]         in_ra_addr,
  input  logic [REG_AW-1:0]         in_rb_addr,
  input  logic [1:0]                in_src_used,
  input  logic [DATA_W-1:0]         in_rf_data_a,
  input  logic [DATA_W-1:0]         in_rf_data_b,
  input  logic [REG_AW-1:0]         in_dst_addr,
  input  logic                      in_gpr_we_,
  input  logic                      in_is_load,
  input  logic [PAYLOAD_W-1:0]      in_payload,
  input  logic [NUM_FWD-1:0]        fwd_we_,
  input  logic [NUM_FWD-1:0]        fwd_rdy,
  input  logic [NUM_FWD*REG_AW-1:0] fwd_addr,
  input  logic [NUM_FWD*DATA_W-1:0] fwd_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [DATA_W-1:0]         out_ra_data,
  output logic [DATA_W-1:0]         out_rb_data,
  output logic [REG_AW-1:0]         out_ra_addr,
  output logic [REG_AW-1:0]         out_rb_addr,
  output logic [REG_AW-1:0]         out_dst_addr,
  output logic                      out_gpr_we_,
  output logic                      out_is_load,
  output logic [PAYLOAD_W-1:0]      out_payload,
  output logic                      hazard,
  output logic [CNT_W-1:0]          ilock_cnt
);

  localparam int unsigned EW = entry_w(DATA_W, REG_AW, PAYLOAD_W);
  // Reset entry: everything zero except the active-low write enable.
  localparam logic [EW-1:0] RST_ENTRY =
      {{(EW-PAYLOAD_W-2){1'b0}}, 1'b1, 1'b0, {PAYLOAD_W{1'b0}}};

  logic [DATA_W-1:0] ra_data, rb_data;
  logic              hazard_a, hazard_b;
  logic [EW-1:0]     in_entry, main_q, skid_q;
  logic              main_valid_q, skid_valid_q;
  logic [CNT_W-1:0]  ilock_q;
  logic              accept, consume;

  id_fwd_sel #(
    .DATA_W  (DATA_W),
    .REG_AW  (REG_AW),
    .NUM_FWD (NUM_FWD),
    .ZERO_REG(ZERO_REG)
  ) u_sel_a (
    .used    (in_src_used[SRC_USED_A]),
    .addr    (in_ra_addr),
    .rf_data (in_rf_data_a),
    .fwd_we_ (fwd_we_),
    .fwd_rdy (fwd_rdy),
    .fwd_addr(fwd_addr),
    .fwd_data(fwd_data),
    .data    (ra_data),
    .hazard  (hazard_a)
  );

  id_fwd_sel #(
    .DATA_W  (DATA_W),
    .REG_AW  (REG_AW),
    .NUM_FWD (NUM_FWD),
    .ZERO_REG(ZERO_REG)
  ) u_sel_b (
    .used    (in_src_used[SRC_USED_B]),
    .addr    (in_rb_addr),
    .rf_data (in_rf_data_b),
    .fwd_we_ (fwd_we_),
    .fwd_rdy (fwd_rdy),
    .fwd_addr(fwd_addr),
    .fwd_data(fwd_data),
    .data    (rb_data),
    .hazard  (hazard_b)
  );

  assign hazard   = in_valid & (hazard_a | hazard_b);
  assign in_ready = ~skid_valid_q;
  assign accept   = in_valid & in_ready & ~hazard & ~flush;
  assign consume  = main_valid_q & out_ready;
  assign in_entry = {ra_data, rb_data, in_ra_addr, in_rb_addr, in_dst_addr,
                     in_gpr_we_, in_is_load, in_payload};

  // skid_valid implies main_valid, and in_ready=0 blocks accept while the skid drains.
  always_ff @(posedge clk) begin
    if (!reset) begin
      main_q       <= RST_ENTRY;
      skid_q       <= RST_ENTRY;
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
    end else if (flush) begin
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
    end else if (skid_valid_q) begin
      if (out_ready) begin
        main_q       <= skid_q;
        skid_valid_q <= 1'b0;
      end
    end else if (accept) begin
      if (!main_valid_q || out_ready) begin
        main_q       <= in_entry;
        main_valid_q <= 1'b1;
      end else begin
        skid_q       <= in_entry;
        skid_valid_q <= 1'b1;
      end
    end else if (consume) begin
      main_valid_q <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      ilock_q <= '0;
    end else if (hazard && !flush && ilock_q != {CNT_W{1'b1}}) begin
      ilock_q <= ilock_q + 1'b1;
    end
  end

  assign out_valid = main_valid_q;
  assign ilock_cnt = ilock_q;
  assign {out_ra_data, out_rb_data, out_ra_addr, out_rb_addr, out_dst_addr,
          out_gpr_we_, out_is_load, out_payload} = main_q;

endmodule

// File: tb/tb_id_issue_reg.sv
// Self-checking bench for id_issue_reg: directed vector table, skid/flush/saturation
// sequences and randomized traffic against a queue-based reference model.
module tb_id_issue_reg;
  import id_issue_pkg::*;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NF = 3;
  localparam int PW = 48;
  localparam int CW = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           reset, flush, in_valid, in_ready, out_valid, out_ready, hazard;
  logic [AW-1:0]  in_ra_addr, in_rb_addr, in_dst_addr;
  logic [1:0]     in_src_used;
  logic [DW-1:0]  in_rf_data_a, in_rf_data_b;
  logic           in_gpr_we_, in_is_load;
  logic [PW-1:0]  in_payload;
  logic [NF-1:0]  fwd_we_, fwd_rdy;
  logic [AW-1:0]  f_addr[NF];
  logic [DW-1:0]  f_data[NF];
  logic [NF*AW-1:0] fwd_addr;
  logic [NF*DW-1:0] fwd_data;
  logic [DW-1:0]  out_ra_data, out_rb_data;
  logic [AW-1:0]  out_ra_addr, out_rb_addr, out_dst_addr;
  logic           out_gpr_we_, out_is_load;
  logic [PW-1:0]  out_payload;
  logic [CW-1:0]  ilock_cnt;

  assign fwd_addr = {f_addr[2], f_addr[1], f_addr[0]};
  assign fwd_data = {f_data[2], f_data[1], f_data[0]};

  id_issue_reg #(
    .DATA_W(DW), .REG_AW(AW), .NUM_FWD(NF), .PAYLOAD_W(PW), .CNT_W(CW), .ZERO_REG(1)
  ) dut (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_ra_addr(in_ra_addr), .in_rb_addr(in_rb_addr), .in_src_used(in_src_used),
    .in_rf_data_a(in_rf_data_a), .in_rf_data_b(in_rf_data_b), .in_dst_addr(in_dst_addr),
    .in_gpr_we_(in_gpr_we_), .in_is_load(in_is_load), .in_payload(in_payload),
    .fwd_we_(fwd_we_), .fwd_rdy(fwd_rdy), .fwd_addr(fwd_addr), .fwd_data(fwd_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_ra_data(out_ra_data),
    .out_rb_data(out_rb_data), .out_ra_addr(out_ra_addr), .out_rb_addr(out_rb_addr),
    .out_dst_addr(out_dst_addr), .out_gpr_we_(out_gpr_we_), .out_is_load(out_is_load),
    .out_payload(out_payload), .hazard(hazard), .ilock_cnt(ilock_cnt)
  );

  typedef struct {
    logic [DW-1:0] ra_data, rb_data;
    logic [AW-1:0] ra, rb, dst;
    logic          we, ld;
    logic [PW-1:0] pl;
  } ent_t;

  typedef struct {
    logic [AW-1:0] ra, rb;
    logic [1:0]    used;
    logic [2:0]    we_, rdy;
    logic [AW-1:0] fa0, fa1, fa2;
    logic [DW-1:0] fd0, fd1, fd2;
    logic          hz;
    logic [DW-1:0] exp_a, exp_b;
  } vec_t;

  ent_t q[$];
  int   cnt;
  int   checks = 0;
  int   errors = 0;
  vec_t tv[8];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Forwarding rule: addr 0 reads 0; else the youngest enabled matching source wins.
  function automatic void resolve(input logic used, input logic [AW-1:0] a,
                                  input logic [DW-1:0] rf, output logic [DW-1:0] d,
                                  output logic hz);
    d  = rf;
    hz = 1'b0;
    if (a == '0) begin
      d = '0;
      return;
    end
    if (!used) return;
    for (int i = 0; i < NF; i++) begin
      if (!fwd_we_[i] && f_addr[i] == a) begin
        if (fwd_rdy[i]) d = f_data[i];
        else            hz = 1'b1;
        return;
      end
    end
  endfunction

  task automatic compare();
    logic [DW-1:0] da, db;
    logic ha, hb;
    resolve(in_src_used[0], in_ra_addr, in_rf_data_a, da, ha);
    resolve(in_src_used[1], in_rb_addr, in_rf_data_b, db, hb);
    chk("hazard", hazard, in_valid & (ha | hb));
    chk("in_ready", in_ready, q.size() < 2);
    chk("out_valid", out_valid, q.size() > 0);
    chk("ilock_cnt", ilock_cnt, cnt);
    if (q.size() > 0) begin
      chk("out_ra_data", out_ra_data, q[0].ra_data);
      chk("out_rb_data", out_rb_data, q[0].rb_data);
      chk("out_ra_addr", out_ra_addr, q[0].ra);
      chk("out_rb_addr", out_rb_addr, q[0].rb);
      chk("out_dst_addr", out_dst_addr, q[0].dst);
      chk("out_gpr_we_", out_gpr_we_, q[0].we);
      chk("out_is_load", out_is_load, q[0].ld);
      chk("out_payload", out_payload, q[0].pl);
    end
  endtask

  // One clock: check at negedge, then advance the reference model at posedge.
  task automatic step();
    logic [DW-1:0] da, db;
    logic ha, hb, mh, acc;
    ent_t e;
    @(negedge clk);
    compare();
    resolve(in_src_used[0], in_ra_addr, in_rf_data_a, da, ha);
    resolve(in_src_used[1], in_rb_addr, in_rf_data_b, db, hb);
    mh  = in_valid & (ha | hb);
    acc = in_valid && (q.size() < 2) && !mh && !flush;
    e   = '{da, db, in_ra_addr, in_rb_addr, in_dst_addr, in_gpr_we_, in_is_load, in_payload};
    @(posedge clk);
    if (!reset) begin
      q.delete();
      cnt = 0;
    end else begin
      if (mh && !flush && cnt < CMAX) cnt++;
      if (flush) q.delete();
      else begin
        if (q.size() > 0 && out_ready) void'(q.pop_front());
        if (acc) q.push_back(e);
      end
    end
    #1;
  endtask

  task automatic idle_inputs();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_ra_addr = '0; in_rb_addr = '0; in_src_used = 2'b11; in_dst_addr = '0;
    in_rf_data_a = '0; in_rf_data_b = '0; in_gpr_we_ = 1'b0; in_is_load = 1'b0;
    in_payload = '0; fwd_we_ = '1; fwd_rdy = '1;
    for (int i = 0; i < NF; i++) begin
      f_addr[i] = '0;
      f_data[i] = '0;
    end
  endtask

  task automatic drive(input logic [AW-1:0] ra, input logic [AW-1:0] rb,
                       input logic [DW-1:0] rfa, input logic [DW-1:0] rfb,
                       input logic [PW-1:0] pl);
    in_valid = 1'b1; in_ra_addr = ra; in_rb_addr = rb; in_src_used = 2'b11;
    in_rf_data_a = rfa; in_rf_data_b = rfb; in_dst_addr = ra ^ rb; in_payload = pl;
  endtask

  initial begin
    tv[0] = '{5, 9, 2'b11, 3'b010, 3'b111, 5, 0, 5, 32'h11, 0, 32'h33, 0, 32'h11, 32'hB0B0B0B0};
    tv[1] = '{5, 9, 2'b11, 3'b011, 3'b111, 5, 0, 5, 32'h11, 0, 32'h33, 0, 32'h33, 32'hB0B0B0B0};
    tv[2] = '{1, 7, 2'b11, 3'b110, 3'b110, 7, 0, 0, 32'h77, 0, 0, 1, 0, 0};
    tv[3] = '{1, 7, 2'b11, 3'b101, 3'b111, 0, 7, 0, 0, 32'h7, 0, 0, 32'hA0A0A0A0, 32'h7};
    tv[4] = '{0, 2, 2'b11, 3'b110, 3'b111, 0, 0, 0, 32'hDEAD, 0, 0, 0, 0, 32'hB0B0B0B0};
    tv[5] = '{3, 2, 2'b10, 3'b110, 3'b110, 3, 0, 0, 32'h3, 0, 0, 0, 32'hA0A0A0A0, 32'hB0B0B0B0};
    tv[6] = '{4, 4, 2'b11, 3'b100, 3'b101, 4, 4, 0, 32'h44, 32'h55, 0, 0, 32'h44, 32'h44};
    tv[7] = '{4, 6, 2'b11, 3'b001, 3'b101, 0, 4, 4, 0, 32'h55, 32'h66, 1, 0, 0};

    idle_inputs();
    q.delete();
    cnt = 0;

    // Reset held with a valid instruction on the input.
    reset = 1'b0;
    drive(3, 4, 32'h1234, 32'h5678, 48'hABC);
    step();
    step();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_gpr_we_", out_gpr_we_, 1);
    chk("rst_ra_data", out_ra_data, 0);
    chk("rst_payload", out_payload, 0);
    chk("rst_ilock", ilock_cnt, 0);
    reset = 1'b1;
    in_valid = 1'b0;
    #1;
    chk("rst_in_ready", in_ready, 1);

    // Directed forwarding vectors with EX always ready.
    for (int k = 0; k < 8; k++) begin
      drive(tv[k].ra, tv[k].rb, 32'hA0A0A0A0, 32'hB0B0B0B0, PW'(k));
      in_src_used = tv[k].used;
      fwd_we_ = tv[k].we_; fwd_rdy = tv[k].rdy;
      f_addr[0] = tv[k].fa0; f_addr[1] = tv[k].fa1; f_addr[2] = tv[k].fa2;
      f_data[0] = tv[k].fd0; f_data[1] = tv[k].fd1; f_data[2] = tv[k].fd2;
      #1;
      chk($sformatf("vec%0d_hazard", k), hazard, tv[k].hz);
      step();
      if (k == 2) chk("vec2_ilock", ilock_cnt, 1);
      if (!tv[k].hz) begin
        chk($sformatf("vec%0d_valid", k), out_valid, 1);
        chk($sformatf("vec%0d_ra", k), out_ra_data, tv[k].exp_a);
        chk($sformatf("vec%0d_rb", k), out_rb_data, tv[k].exp_b);
      end
    end

    idle_inputs();
    step();
    step();

    // Back-to-back accepts under backpressure fill main then skid.
    out_ready = 1'b0;
    drive(1, 2, 32'd100, 32'd200, 48'hA);
    step();
    drive(1, 2, 32'd101, 32'd201, 48'hB);
    step();
    chk("skid_in_ready", in_ready, 0);
    chk("skid_head", out_payload, 48'hA);
    drive(1, 2, 32'd102, 32'd202, 48'hC);
    step();
    in_valid = 1'b0;
    out_ready = 1'b1;
    step();
    chk("skid_second", out_payload, 48'hB);
    chk("skid_second_ra", out_ra_data, 32'd101);
    chk("skid_drained_ready", in_ready, 1);
    step();
    chk("skid_empty", out_valid, 0);

    // Flush with skid full and a valid input.
    out_ready = 1'b0;
    drive(1, 2, 32'd1, 32'd2, 48'hD1);
    step();
    drive(1, 2, 32'd3, 32'd4, 48'hD2);
    step();
    drive(1, 2, 32'd5, 32'd6, 48'hD3);
    flush = 1'b1;
    step();
    flush = 1'b0;
    in_valid = 1'b0;
    chk("flush_valid", out_valid, 0);
    chk("flush_ready", in_ready, 1);
    out_ready = 1'b1;
    step();
    chk("flush_nothing", out_valid, 0);

    // Persistent load-use hazard saturates the counter.
    fwd_we_ = 3'b110; fwd_rdy = 3'b110; f_addr[0] = 9;
    drive(9, 1, 0, 0, 48'hE);
    repeat (CMAX + 4) step();
    chk("ilock_sat", ilock_cnt, CMAX);
    chk("ilock_sat_novalid", out_valid, 0);
    idle_inputs();
    step();

    // Randomized traffic against the reference model.
    for (int n = 0; n < 800; n++) begin
      reset     = ($urandom_range(0, 99) != 0);
      flush     = ($urandom_range(0, 19) == 0);
      in_valid  = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 9) < 6);
      in_ra_addr   = AW'($urandom_range(0, 7));
      in_rb_addr   = AW'($urandom_range(0, 7));
      in_src_used  = 2'($urandom);
      in_rf_data_a = $urandom;
      in_rf_data_b = $urandom;
      in_dst_addr  = AW'($urandom);
      in_gpr_we_   = 1'($urandom);
      in_is_load   = 1'($urandom);
      in_payload   = {16'($urandom), 32'($urandom)};
      for (int i = 0; i < NF; i++) begin
        fwd_we_[i] = 1'($urandom);
        fwd_rdy[i] = ($urandom_range(0, 9) < 8);
        f_addr[i]  = AW'($urandom_range(0, 7));
        f_data[i]  = $urandom;
      end
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
